ex_redirect_ctrl: RTL and testbench

//  Parametrised EX-stage control unit: resolves branch/JAL/JALR/external-flush redirects, drives PC select and redirect PC,
//  and kills the wrong-path slots behind a redirect for a configurable depth.

---
 rtl/ex_redirect_ctrl.sv | 127 ++++++++++++
 tb/tb_ex_redirect_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_redirect_ctrl.sv
// EX-stage redirect control: resolves B/JAL/JALR/flush redirects, kills FLUSH_DEPTH wrong-path slots.
// Latency: pc_sel/redirect_pc one cycle after resolve; memrw_ex combinational, *_ex_q registered.
// No backpressure; optional perf counters built when CTRL_EX_PERF_EN is defined.
module ex_redirect_ctrl #(
    parameter int FLUSH_DEPTH = 3,
    parameter int LDSEL_W     = 3,
    parameter int WBSEL_W     = 2,
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        inst,
    input  logic               br_eq,
    input  logic               br_lt,
    input  logic [31:0]        br_target,
    input  logic               flush_req,
    input  logic [31:0]        flush_pc,
    input  logic               hold_d,
    input  logic [1:0]         memrw_d,
    input  logic               regwen_d,
    input  logic [LDSEL_W-1:0] ldsel_d,
    input  logic [WBSEL_W-1:0] wbsel_d,
    input  logic               csrsel_d,
    output logic [1:0]         memrw_ex,
    output logic               regwen_ex_q,
    output logic [LDSEL_W-1:0] ldsel_ex_q,
    output logic [WBSEL_W-1:0] wbsel_ex_q,
    output logic               csrsel_ex_q,
    output logic               pc_sel,
    output logic [31:0]        redirect_pc,
    output logic               kill,
    output logic [CNT_W-1:0]   perf_br,
    output logic [CNT_W-1:0]   perf_taken,
    output logic [CNT_W-1:0]   perf_kill
);
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_JAL    = 5'b11011;

    logic [FLUSH_DEPTH-1:0] kill_sr;
    logic [FLUSH_DEPTH-1:0] kill_sr_nxt;
    logic                   is_br;
    logic                   is_jal;
    logic                   is_jalr;
    logic                   br_taken;
    logic                   det_br;
    logic                   det;
    logic                   unused_inst;

    assign unused_inst = ^{inst[31:15], inst[11:7], inst[1:0]};

    assign kill     = |kill_sr;
    assign pc_sel   = kill_sr[0];
    assign memrw_ex = (kill || hold_d) ? 2'b00 : memrw_d;

    always_comb begin
        is_br   = (inst[6:2] == OP_BRANCH);
        is_jal  = (inst[6:2] == OP_JAL);
        is_jalr = (inst[6:2] == OP_JALR);
        case (inst[14:12])
            3'b000:         br_taken = br_eq;
            3'b001:         br_taken = !br_eq;
            3'b100, 3'b110: br_taken = br_lt;
            3'b101, 3'b111: br_taken = !br_lt;
            default:        br_taken = 1'b0;
        endcase
        // Wrong-path and bubble slots never redirect; external flushes always do.
        det_br = !hold_d && !kill && ((is_br && br_taken) || is_jal || is_jalr);
        det    = flush_req || det_br;
        kill_sr_nxt    = '0;
        kill_sr_nxt[0] = det;
        for (int i = 1; i < FLUSH_DEPTH; i++) begin
            kill_sr_nxt[i] = kill_sr[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            kill_sr     <= '0;
            redirect_pc <= '0;
            regwen_ex_q <= 1'b0;
            ldsel_ex_q  <= '0;
            wbsel_ex_q  <= '0;
            csrsel_ex_q <= 1'b0;
        end else begin
            kill_sr <= kill_sr_nxt;
            if (det) begin
                redirect_pc <= flush_req ? flush_pc : br_target;
            end
            regwen_ex_q <= (kill || hold_d) ? 1'b0 : regwen_d;
            ldsel_ex_q  <= kill ? '0 : ldsel_d;
            wbsel_ex_q  <= kill ? '0 : wbsel_d;
            csrsel_ex_q <= kill ? 1'b0 : csrsel_d;
        end
    end

`ifdef CTRL_EX_PERF_EN
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] taken_cnt;
    logic [CNT_W-1:0] kill_cnt;
    logic             br_seen;

    assign br_seen = (is_br || is_jal || is_jalr) && !hold_d && !kill;

    // Counters saturate rather than wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            br_cnt    <= '0;
            taken_cnt <= '0;
            kill_cnt  <= '0;
        end else begin
            if (br_seen && (br_cnt != '1))   br_cnt    <= br_cnt + CNT_W'(1);
            if (det_br && (taken_cnt != '1)) taken_cnt <= taken_cnt + CNT_W'(1);
            if (kill && (kill_cnt != '1))    kill_cnt  <= kill_cnt + CNT_W'(1);
        end
    end

    assign perf_br    = br_cnt;
    assign perf_taken = taken_cnt;
    assign perf_kill  = kill_cnt;
`else
    assign perf_br    = '0;
    assign perf_taken = '0;
    assign perf_kill  = '0;
`endif

endmodule

// File: tb/tb_ex_redirect_ctrl.sv
// Directed table-driven bench for ex_redirect_ctrl (depth 3) plus a depth-1 instance for perf/short-window cases.
module tb_ex_redirect_ctrl;
    localparam logic [31:0] BEQ  = 32'h0020_8063;
    localparam logic [31:0] BNE  = 32'h0020_9063;
    localparam logic [31:0] BF2  = 32'h0020_A063;
    localparam logic [31:0] BLT  = 32'h0020_C063;
    localparam logic [31:0] BGE  = 32'h0020_D063;
    localparam logic [31:0] BGEU = 32'h0020_F063;
    localparam logic [31:0] JAL  = 32'h0080_00EF;
    localparam logic [31:0] JALR = 32'h0000_80E7;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] SW   = 32'h0020_A023;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst, br_target, flush_pc;
    logic        br_eq, br_lt, flush_req, hold_d, regwen_d, csrsel_d;
    logic [1:0]  memrw_d, wbsel_d;
    logic [2:0]  ldsel_d;
    logic [1:0]  memrw_ex, wbsel_ex_q;
    logic        regwen_ex_q, csrsel_ex_q, pc_sel, kill;
    logic [2:0]  ldsel_ex_q;
    logic [31:0] redirect_pc, perf_br, perf_taken, perf_kill;

    logic        b_rst;
    logic [31:0] b_inst, b_tgt;
    logic        b_eq, b_lt;
    logic        z1 = 1'b0;
    logic [31:0] z32 = 32'h0;
    logic [1:0]  z2 = 2'b00;
    logic [2:0]  z3 = 3'b000;
    logic [1:0]  b_memrw_ex, b_wbsel_q;
    logic        b_regwen_q, b_csrsel_q, b_pc_sel, b_kill;
    logic [2:0]  b_ldsel_q;
    logic [31:0] b_rpc, b_perf_br, b_perf_taken, b_perf_kill;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ex_redirect_ctrl #(.FLUSH_DEPTH(3)) dut (
        .clk(clk), .rst(rst), .inst(inst), .br_eq(br_eq), .br_lt(br_lt),
        .br_target(br_target), .flush_req(flush_req), .flush_pc(flush_pc),
        .hold_d(hold_d), .memrw_d(memrw_d), .regwen_d(regwen_d), .ldsel_d(ldsel_d),
        .wbsel_d(wbsel_d), .csrsel_d(csrsel_d), .memrw_ex(memrw_ex),
        .regwen_ex_q(regwen_ex_q), .ldsel_ex_q(ldsel_ex_q), .wbsel_ex_q(wbsel_ex_q),
        .csrsel_ex_q(csrsel_ex_q), .pc_sel(pc_sel), .redirect_pc(redirect_pc),
        .kill(kill), .perf_br(perf_br), .perf_taken(perf_taken), .perf_kill(perf_kill)
    );

    ex_redirect_ctrl #(.FLUSH_DEPTH(1)) dut1 (
        .clk(clk), .rst(b_rst), .inst(b_inst), .br_eq(b_eq), .br_lt(b_lt),
        .br_target(b_tgt), .flush_req(z1), .flush_pc(z32),
        .hold_d(z1), .memrw_d(z2), .regwen_d(z1), .ldsel_d(z3),
        .wbsel_d(z2), .csrsel_d(z1), .memrw_ex(b_memrw_ex),
        .regwen_ex_q(b_regwen_q), .ldsel_ex_q(b_ldsel_q), .wbsel_ex_q(b_wbsel_q),
        .csrsel_ex_q(b_csrsel_q), .pc_sel(b_pc_sel), .redirect_pc(b_rpc),
        .kill(b_kill), .perf_br(b_perf_br), .perf_taken(b_perf_taken), .perf_kill(b_perf_kill)
    );

    typedef struct {
        logic        rst;
        logic [31:0] inst;
        logic        eq, lt;
        logic [31:0] tgt;
        logic        fl;
        logic [31:0] fpc;
        logic        hold;
        logic [1:0]  memrw;
        logic        regwen;
        logic [2:0]  ld;
        logic [1:0]  e_memrw;
        logic        e_regwen;
        logic [2:0]  e_ld;
        logic        e_pc;
        logic        e_kill;
        logic [31:0] e_rpc;
    } vec_t;

    vec_t tbl[30];

    function automatic vec_t mkv(input int r, input int in, input int eq, input int lt,
                                 input int tgt, input int fl, input int fpc, input int hold,
                                 input int memrw, input int regwen, input int ld,
                                 input int e_memrw, input int e_regwen, input int e_ld,
                                 input int e_pc, input int e_kill, input int e_rpc);
        vec_t v;
        v.rst = 1'(r);         v.inst = 32'(in);      v.eq = 1'(eq);       v.lt = 1'(lt);
        v.tgt = 32'(tgt);      v.fl = 1'(fl);         v.fpc = 32'(fpc);    v.hold = 1'(hold);
        v.memrw = 2'(memrw);   v.regwen = 1'(regwen); v.ld = 3'(ld);
        v.e_memrw = 2'(e_memrw); v.e_regwen = 1'(e_regwen); v.e_ld = 3'(e_ld);
        v.e_pc = 1'(e_pc);     v.e_kill = 1'(e_kill); v.e_rpc = 32'(e_rpc);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp_v);
        end
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst; inst = v.inst; br_eq = v.eq; br_lt = v.lt; br_target = v.tgt;
        flush_req = v.fl; flush_pc = v.fpc; hold_d = v.hold; memrw_d = v.memrw;
        regwen_d = v.regwen; ldsel_d = v.ld; wbsel_d = v.ld[1:0]; csrsel_d = v.ld[2];
    endtask

    task automatic b_step(input logic [31:0] in, input logic eq, input logic lt, input logic [31:0] tgt);
        @(negedge clk);
        b_inst = in; b_eq = eq; b_lt = lt; b_tgt = tgt;
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        //            rst inst  eq lt tgt    fl fpc    hd mrw rw ld | memrw rw ld pc kill rpc
        tbl[0]  = mkv(0, BEQ,  1, 0, 'h100, 0, 0,     0, 0, 0, 1,  0, 0, 0, 0, 0, 'h0);
        tbl[1]  = mkv(0, NOP,  0, 0, 0,     0, 0,     0, 1, 1, 2,  0, 0, 1, 1, 1, 'h100);
        tbl[2]  = mkv(0, NOP,  0, 0, 0,     0, 0,     0, 2, 1, 3,  0, 0, 0, 0, 1, 'h100);
        tbl[3]  = mkv(0, NOP,  0, 0, 0,     0, 0,     0, 0, 1, 4,  0, 0, 0, 0, 1, 'h100);
        tbl[4]  = mkv(0, NOP,  0, 0, 0,     0, 0,     0, 3, 1, 6,  3, 0, 0, 0, 0, 'h100);
        tbl[5]  = mkv(0, BNE,  1, 0, 'h180, 0, 0,     0, 0, 0, 1,  0, 1, 6, 0, 0, 'h100);
        tbl[6]  = mkv(0, SW,   0, 0, 0,     0, 0,     0, 1, 0, 2,  1, 0, 1, 0, 0, 'h100);
        tbl[7]  = mkv(0, JAL,  0, 0, 'h400, 0, 0,     0, 0, 1, 3,  0, 0, 2, 0, 0, 'h100);
        tbl[8]  = mkv(0, BEQ,  1, 0, 'h500, 0, 0,     0, 1, 1, 4,  0, 1, 3, 1, 1, 'h400);
        tbl[9]  = mkv(0, BNE,  0, 0, 'h504, 0, 0,     0, 2, 1, 5,  0, 0, 0, 0, 1, 'h400);
        tbl[10] = mkv(0, JALR, 0, 0, 'h508, 0, 0,     0, 3, 1, 6,  0, 0, 0, 0, 1, 'h400);
        tbl[11] = mkv(0, NOP,  0, 0, 0,     0, 0,     0, 1, 1, 7,  1, 0, 0, 0, 0, 'h400);
        tbl[12] = mkv(0, BLT,  0, 1, 'h300, 1, 'h200, 0, 0, 0, 1,  0, 1, 7, 0, 0, 'h400);
        tbl[13] = mkv(0, NOP,  0, 0, 0,     0, 0,     0, 1, 1, 2,  0, 0, 1, 1, 1, 'h200);
        tbl[14] = mkv(0, NOP,  0, 0, 0,     1, 'h240, 0, 1, 1, 3,  0, 0, 0, 0, 1, 'h200);
        tbl[15] = mkv(0, NOP,  0, 0, 0,     0, 0,     0, 1, 1, 4,  0, 0, 0, 1, 1, 'h240);
        tbl[16] = mkv(0, NOP,  0, 0, 0,     0, 0,     0, 1, 1, 4,  0, 0, 0, 0, 1, 'h240);
        tbl[17] = mkv(0, NOP,  0, 0, 0,     0, 0,     0, 1, 1, 4,  0, 0, 0, 0, 1, 'h240);
        tbl[18] = mkv(0, NOP,  0, 0, 0,     0, 0,     0, 2, 1, 5,  2, 0, 0, 0, 0, 'h240);
        tbl[19] = mkv(0, JALR, 0, 0, 'h600, 0, 0,     1, 3, 1, 6,  0, 1, 5, 0, 0, 'h240);
        tbl[20] = mkv(0, NOP,  0, 0, 0,     0, 0,     0, 0, 1, 7,  0, 0, 6, 0, 0, 'h240);
        tbl[21] = mkv(0, BGE,  0, 1, 'h700, 0, 0,     0, 0, 0, 0,  0, 1, 7, 0, 0, 'h240);
        tbl[22] = mkv(0, BF2,  1, 1, 'h704, 0, 0,     0, 0, 0, 0,  0, 0, 0, 0, 0, 'h240);
        tbl[23] = mkv(0, BGEU, 0, 0, 'h800, 0, 0,     0, 0, 1, 1,  0, 0, 0, 0, 0, 'h240);
        tbl[24] = mkv(0, NOP,  0, 0, 0,     0, 0,     0, 0, 1, 2,  0, 1, 1, 1, 1, 'h800);
        tbl[25] = mkv(1, NOP,  0, 0, 0,     0, 0,     0, 2, 1, 3,  0, 0, 0, 0, 1, 'h800);
        tbl[26] = mkv(0, NOP,  0, 0, 0,     0, 0,     0, 2, 1, 4,  2, 0, 0, 0, 0, 'h0);
        tbl[27] = mkv(0, NOP,  0, 0, 0,     0, 0,     0, 0, 1, 4,  0, 1, 4, 0, 0, 'h0);
        tbl[28] = mkv(0, NOP,  0, 0, 0,     1, 'h900, 1, 1, 1, 5,  0, 1, 4, 0, 0, 'h0);
        tbl[29] = mkv(0, NOP,  0, 0, 0,     0, 0,     0, 1, 1, 6,  0, 0, 5, 1, 1, 'h900);

        b_rst = 1'b1; b_inst = NOP; b_eq = 1'b0; b_lt = 1'b0; b_tgt = 32'h0;
        drive(mkv(1, NOP, 0, 0, 0, 0, 0, 0, 2, 1, 5, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_kill", 32'(kill), 32'h0);
        chk("rst_pc_sel", 32'(pc_sel), 32'h0);
        chk("rst_redirect_pc", redirect_pc, 32'h0);
        chk("rst_regwen_q", 32'(regwen_ex_q), 32'h0);
        chk("rst_ldsel_q", 32'(ldsel_ex_q), 32'h0);
        chk("rst_wbsel_q", 32'(wbsel_ex_q), 32'h0);
        chk("rst_csrsel_q", 32'(csrsel_ex_q), 32'h0);
        chk("rst_memrw_ex", 32'(memrw_ex), 32'h2);
        chk("rst_perf_br", perf_br, 32'h0);
        chk("rst_perf_kill", perf_kill, 32'h0);

        for (int i = 0; i < 30; i++) begin
            if (i > 0) @(negedge clk);
            drive(tbl[i]);
            #1;
            chk($sformatf("v%0d_memrw_ex", i), 32'(memrw_ex), 32'(tbl[i].e_memrw));
            chk($sformatf("v%0d_regwen_q", i), 32'(regwen_ex_q), 32'(tbl[i].e_regwen));
            chk($sformatf("v%0d_ldsel_q", i), 32'(ldsel_ex_q), 32'(tbl[i].e_ld));
            chk($sformatf("v%0d_wbsel_q", i), 32'(wbsel_ex_q), 32'(tbl[i].e_ld[1:0]));
            chk($sformatf("v%0d_csrsel_q", i), 32'(csrsel_ex_q), 32'(tbl[i].e_ld[2]));
            chk($sformatf("v%0d_pc_sel", i), 32'(pc_sel), 32'(tbl[i].e_pc));
            chk($sformatf("v%0d_kill", i), 32'(kill), 32'(tbl[i].e_kill));
            chk($sformatf("v%0d_redirect_pc", i), redirect_pc, tbl[i].e_rpc);
        end
`ifndef CTRL_EX_PERF_EN
        chk("noperf_br", perf_br, 32'h0);
        chk("noperf_taken", perf_taken, 32'h0);
        chk("noperf_kill", perf_kill, 32'h0);
`endif

        // Depth-1 instance: single-cycle kill window and perf counting.
        @(negedge clk); b_rst = 1'b0;
        b_step(BEQ, 1'b1, 1'b0, 32'h10);
        chk("d1_c0_pc_sel", 32'(b_pc_sel), 32'h0);
        chk("d1_c0_kill", 32'(b_kill), 32'h0);
        b_step(NOP, 1'b0, 1'b0, 32'h0);
        chk("d1_c1_pc_sel", 32'(b_pc_sel), 32'h1);
        chk("d1_c1_kill", 32'(b_kill), 32'h1);
        chk("d1_c1_rpc", b_rpc, 32'h10);
        b_step(BNE, 1'b1, 1'b0, 32'h18);
        chk("d1_c2_kill", 32'(b_kill), 32'h0);
        b_step(BLT, 1'b0, 1'b1, 32'h20);
        chk("d1_c3_pc_sel", 32'(b_pc_sel), 32'h0);
        b_step(NOP, 1'b0, 1'b0, 32'h0);
        chk("d1_c4_pc_sel", 32'(b_pc_sel), 32'h1);
        chk("d1_c4_kill", 32'(b_kill), 32'h1);
        chk("d1_c4_rpc", b_rpc, 32'h20);
        b_step(BEQ, 1'b0, 1'b0, 32'h28);
        chk("d1_c5_kill", 32'(b_kill), 32'h0);
        b_step(NOP, 1'b0, 1'b0, 32'h0);
        chk("d1_c6_pc_sel", 32'(b_pc_sel), 32'h0);
        chk("d1_c6_rpc", b_rpc, 32'h20);
`ifdef CTRL_EX_PERF_EN
        chk("d1_perf_br", b_perf_br, 32'd4);
        chk("d1_perf_taken", b_perf_taken, 32'd2);
        chk("d1_perf_kill", b_perf_kill, 32'd2);
`else
        chk("d1_perf_br", b_perf_br, 32'd0);
        chk("d1_perf_taken", b_perf_taken, 32'd0);
        chk("d1_perf_kill", b_perf_kill, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
